uart_apb_fifo: RTL

APB3 slave UART with parametrised TX/RX FIFOs, a programmable baud divisor, sticky error flags and a maskable interrupt. It replaces the fixed 16550-style wrapper on the peripheral bus. All registers are 32-bit word-aligned, so no byte-lane/strobe address remapping is needed.
Serial format is fixed at 8N1.

---
 rtl/uart_apb_pkg.sv | 28 ++
 rtl/uart_sync_fifo.sv | 53 +++++
 rtl/uart_apb_fifo.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_apb_pkg.sv
// Shared constants and state types for the APB UART: register offsets,
// STATUS/CTRL bit positions and the serial engine state encodings.
package uart_apb_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int ST_TX_FULL      = 0;
    localparam int ST_TX_EMPTY     = 1;
    localparam int ST_RX_FULL      = 2;
    localparam int ST_RX_EMPTY     = 3;
    localparam int ST_RX_OVERRUN   = 4;
    localparam int ST_RX_FRAME_ERR = 5;
    localparam int ST_TX_BUSY      = 6;

    localparam int CTRL_TX_EN     = 0;
    localparam int CTRL_RX_EN     = 1;
    localparam int CTRL_IRQ_RX_EN = 2;
    localparam int CTRL_IRQ_TX_EN = 3;

    localparam int FRAME_BITS = 8;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy count; a pop on a full FIFO frees the slot
// for a push in the same cycle.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & !empty;
    assign do_push = push & (!full | do_pop);
    assign rdata   = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_apb_fifo.sv
// APB3 slave 8N1 UART with TX/RX FIFOs, programmable divisor, sticky errors
// and a registered level interrupt.
//   state    | meaning
//   TX_IDLE  | line high, waiting for tx_en and data
//   TX_START | driving start bit (DIV+1 clocks)
//   TX_DATA  | shifting 8 data bits LSB first
//   TX_STOP  | driving stop bit, may chain straight into next frame
//   RX_IDLE  | waiting for a falling edge with rx_en
//   RX_START | waiting to mid-sample start bit, high = glitch
//   RX_DATA  | sampling 8 data bits every DIV+1 clocks
//   RX_STOP  | sampling stop bit, then push / flag error
module uart_apb_fifo
    import uart_apb_pkg::*;
#(
    parameter int TX_DEPTH  = 16,
    parameter int RX_DEPTH  = 16,
    parameter int DIV_W     = 16,
    parameter int DIV_RESET = 867
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_psel,
    input  logic        in_penable,
    input  logic [2:0]  in_pprot,
    input  logic [31:0] in_paddr,
    input  logic        in_pwrite,
    input  logic [31:0] in_pwdata,
    input  logic [3:0]  in_pstrb,
    output logic        in_pready,
    output logic        in_pslverr,
    output logic [31:0] in_prdata,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);
    logic [1:0]       reg_addr;
    logic             access, wr_en, rd_en;
    logic             wr_data, rd_data, w1c;
    logic [DIV_W-1:0] div_q, div_eff, start_wait;
    logic [DIV_W:0]   rx_half;
    logic [3:0]       ctrl_q;
    logic             rx_overrun, rx_frame_err;
    logic [6:0]       status;

    logic             tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]       tx_rdata;
    logic [$clog2(TX_DEPTH+1)-1:0] tx_count;
    logic             rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]       rx_rdata;
    logic [$clog2(RX_DEPTH+1)-1:0] rx_count;

    tx_state_t        tx_state;
    logic [DIV_W-1:0] tx_timer, tx_div;
    logic [2:0]       tx_bit;
    logic [7:0]       tx_shift;
    logic             tx_start, tx_busy;

    rx_state_t        rx_state;
    logic [DIV_W-1:0] rx_timer, rx_div;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic             rx_s1, rx_s2, rx_prev;
    logic             rx_stop_tick, rx_stop_ok, rx_ovr_set, rx_ferr_set;
    logic             unused_bits;

    assign unused_bits = ^{in_pprot, in_paddr, in_pwdata, in_pstrb, tx_count, rx_count};

    assign reg_addr   = in_paddr[3:2];
    assign access     = in_psel & in_penable;
    assign wr_en      = access & in_pwrite & in_pstrb[0];
    assign rd_en      = access & !in_pwrite;
    assign wr_data    = wr_en & (reg_addr == REG_DATA);
    assign rd_data    = rd_en & (reg_addr == REG_DATA);
    assign w1c        = wr_en & (reg_addr == REG_STATUS);
    assign tx_push    = wr_data & !tx_full;
    assign rx_pop     = rd_data & !rx_empty;
    assign in_pready  = access;
    assign in_pslverr = (wr_data & tx_full) | (rd_data & rx_empty);

    assign div_eff    = (div_q < DIV_W'(3)) ? DIV_W'(3) : div_q;
    assign rx_half    = ({1'b0, div_eff} + 1'b1) >> 1;
    assign start_wait = DIV_W'(rx_half - 1'b1);

    always_comb begin
        status                  = '0;
        status[ST_TX_FULL]      = tx_full;
        status[ST_TX_EMPTY]     = tx_empty;
        status[ST_RX_FULL]      = rx_full;
        status[ST_RX_EMPTY]     = rx_empty;
        status[ST_RX_OVERRUN]   = rx_overrun;
        status[ST_RX_FRAME_ERR] = rx_frame_err;
        status[ST_TX_BUSY]      = tx_busy;
    end

    always_comb begin
        in_prdata = '0;
        if (in_psel && !in_pwrite) begin
            case (reg_addr)
                REG_DATA:   if (!rx_empty) in_prdata[7:0] = rx_rdata;
                REG_STATUS: in_prdata[6:0] = status;
                REG_DIV:    in_prdata[DIV_W-1:0] = div_q;
                default:    in_prdata[3:0] = ctrl_q;
            endcase
        end
    end

    // hardware set of an error flag beats a simultaneous W1C
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_q        <= DIV_W'(DIV_RESET);
            ctrl_q       <= 4'h3;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
            irq          <= 1'b0;
        end else begin
            if (wr_en && reg_addr == REG_DIV)  div_q  <= in_pwdata[DIV_W-1:0];
            if (wr_en && reg_addr == REG_CTRL) ctrl_q <= in_pwdata[3:0];
            rx_overrun   <= rx_ovr_set  | (rx_overrun   & !(w1c & in_pwdata[ST_RX_OVERRUN]));
            rx_frame_err <= rx_ferr_set | (rx_frame_err & !(w1c & in_pwdata[ST_RX_FRAME_ERR]));
            irq <= (ctrl_q[CTRL_IRQ_RX_EN] & !rx_empty) | (ctrl_q[CTRL_IRQ_TX_EN] & tx_empty)
                 | rx_overrun | rx_frame_err;
        end
    end

    uart_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clock(clock), .reset(reset), .push(tx_push), .wdata(in_pwdata[7:0]),
        .pop(tx_pop), .rdata(tx_rdata), .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    uart_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clock(clock), .reset(reset), .push(rx_push), .wdata(rx_shift),
        .pop(rx_pop), .rdata(rx_rdata), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    // a new frame may start from IDLE or directly at the end of a stop bit
    assign tx_start = ctrl_q[CTRL_TX_EN] & !tx_empty
                    & ((tx_state == TX_IDLE) | ((tx_state == TX_STOP) & (tx_timer == '0)));
    assign tx_pop   = tx_start;
    assign tx_busy  = (tx_state != TX_IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_state <= TX_IDLE;
            tx_timer <= '0;
            tx_div   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            uart_tx  <= 1'b1;
        end else begin
            uart_tx <= (tx_state == TX_START) ? 1'b0 :
                       (tx_state == TX_DATA)  ? tx_shift[0] : 1'b1;
            if (tx_start) begin
                tx_state <= TX_START;
                tx_timer <= div_eff;
                tx_div   <= div_eff;
                tx_shift <= tx_rdata;
                tx_bit   <= '0;
            end else if (tx_state != TX_IDLE) begin
                if (tx_timer != '0) begin
                    tx_timer <= tx_timer - 1'b1;
                end else begin
                    tx_timer <= tx_div;
                    case (tx_state)
                        TX_START: tx_state <= TX_DATA;
                        TX_DATA: begin
                            tx_shift <= tx_shift >> 1;
                            tx_bit   <= tx_bit + 1'b1;
                            if (tx_bit == 3'(FRAME_BITS-1)) tx_state <= TX_STOP;
                        end
                        default: tx_state <= TX_IDLE;
                    endcase
                end
            end
        end
    end

    assign rx_stop_tick = (rx_state == RX_STOP) & (rx_timer == '0);
    assign rx_stop_ok   = rx_stop_tick & rx_s2;
    assign rx_ferr_set  = rx_stop_tick & !rx_s2;
    assign rx_push      = rx_stop_ok & (!rx_full | rx_pop);
    assign rx_ovr_set   = rx_stop_ok & rx_full & !rx_pop;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_timer <= '0;
            rx_div   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            if (rx_state == RX_IDLE) begin
                if (ctrl_q[CTRL_RX_EN] && rx_prev && !rx_s2) begin
                    rx_state <= RX_START;
                    rx_timer <= start_wait;
                    rx_div   <= div_eff;
                end
            end else if (rx_timer != '0) begin
                rx_timer <= rx_timer - 1'b1;
            end else begin
                rx_timer <= rx_div;
                case (rx_state)
                    RX_START: begin
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                        rx_bit   <= '0;
                    end
                    RX_DATA: begin
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 1'b1;
                        if (rx_bit == 3'(FRAME_BITS-1)) rx_state <= RX_STOP;
                    end
                    default: rx_state <= RX_IDLE;
                endcase
            end
        end
    end

endmodule
